parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
Bit-serial receiver and checker for even-parity data frames of the form {d_word, parity_bit}. It shifts in WIDTH+1 bits MSB-first, with the parity bit arriving last. It then recomputes even parity and presents the recovered word with an error flag over a valid/ready output handshake. It sits at the receiving end of the parity-framed serial link and also keeps a saturating parity-error counter and a sticky overrun flag for status readout.

Parameters:
WIDTH, 32, data word width in bits; a frame is WIDTH+1 bits.
CNT_W, 16, width of the parity-error counter.

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
rx_bit  input  1  serial data bit, sampled only when bit_valid=1.
bit_valid  input  1  strobe marking rx_bit as a valid bit this cycle.
frame_start  input  1  qualified by bit_valid; marks rx_bit as the first bit of a frame, d_word[WIDTH-1].
out_ready  input  1  downstream accepts the output word this cycle.
clr_status  input  1  synchronous clear of err_cnt and overrun.
d_word  output  WIDTH  recovered data word.
parity_err  output  1  1 when the presented frame failed even parity.
out_valid  output  1  d_word and parity_err are valid; held until accepted.
busy  output  1  frame reception in progress (SHIFT state).
overrun  output  1  sticky flag: a completed frame was dropped because the output was still occupied.
err_cnt  output  CNT_W  saturating count of completed frames with a parity error.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - d_word=0, parity_err=0, out_valid=0, busy=0, overrun=0, err_cnt=0.
  - Shift register and bit counter cleared; state=IDLE.
  - Reset mid-frame discards the partial frame.
- FSM states: IDLE, SHIFT.
  - IDLE: bit_valid=0, or bit_valid=1 with frame_start=0 -> stay in IDLE; stray bits are ignored.
  - IDLE: bit_valid=1 and frame_start=1 -> load rx_bit into the shift register, set bit count=1, go to SHIFT.
  - SHIFT: bit_valid=1 with frame_start=0 -> shift rx_bit in at the LSB, increment the count. Cycles with bit_valid=0 hold state; there is no timeout.
  - SHIFT: bit_valid=1 with frame_start=1 -> restart. The partial frame is discarded with no flag raised; rx_bit becomes bit 1 of a new frame.
  - When the (WIDTH+1)th bit is taken -> frame complete, return to IDLE.
  - A frame_start coinciding with the final bit's slot is treated as a restart, not as completion.
- busy=1 exactly while in SHIFT.
- Check: the frame is OK when the XOR of all WIDTH+1 bits is 0 (even parity). parity_err = that XOR result.
- Latency: out_valid, d_word and parity_err update on the clock edge that samples the last bit, so they are visible the cycle after the final bit_valid.
- Output handshake:
  - A transfer occurs when out_valid=1 and out_ready=1; out_valid drops the next cycle unless a new frame completes in that same cycle.
  - While out_valid=1 and out_ready=0, d_word and parity_err are held stable.
  - A frame completing with out_valid=1 and out_ready=0 is dropped. The held word is kept and overrun is set.
  - A frame completing with out_valid=1 and out_ready=1 in the same cycle: the old word is transferred, the new word is loaded, out_valid stays 1, and there is no overrun.
- err_cnt:
  - Increments by 1 on every completed frame with a parity error, including dropped (overrun) frames.
  - Saturates at 2^CNT_W-1 with no wrap.
- clr_status=1 clears err_cnt and overrun on the next edge.
  - Clear wins over a simultaneous increment or overrun set.
  - clr_status does not affect the FSM or the output register.
- A back-to-back frame with frame_start on the cycle immediately after the last bit is accepted with no gap required.

Test Plan (WIDTH=8, CNT_W=4):
1. Send 1,0,1,0,0,1,0,1,0 (frame_start on bit 1, bit_valid every cycle) -> next cycle out_valid=1, d_word=0xA5, parity_err=0, err_cnt=0.
2. Send 0xA5 with parity bit 1, with bit_valid gaps of 2 idle cycles between bits -> d_word=0xA5, parity_err=1, err_cnt=1; busy=1 throughout reception.
3. Hold out_ready=0, receive 0x3C/parity 0 then 0xFF/parity 1 -> d_word stays 0x3C and overrun=1. The 0xFF frame has an odd number of ones (9) so err_cnt=1; pulsing clr_status -> overrun=0, err_cnt=0.
4. Drive frame_start after 4 bits of one frame, then a complete 0x81/parity 0 frame -> single output 0x81, parity_err=0, no error counted; 16 erroneous frames -> err_cnt saturates at 0xF.
5. Assert reset_n=0 mid-frame and while out_valid=1 -> all outputs 0 immediately. A subsequent clean 0x01/parity 1 frame yields d_word=0x01, parity_err=0.
6. Complete a frame on the same cycle out_ready=1 accepts a pending word -> both words delivered in order, overrun stays 0.

Source files
------------

// File: rtl/parity_frame_rx_if.sv
// Handshake bundle for parity_frame_rx: the serial bit stream in, and the
// recovered word with its parity flag out under valid/ready.
interface parity_frame_rx_if #(
  parameter int WIDTH = 32
);
  logic             rx_bit;
  logic             bit_valid;
  logic             frame_start;
  logic             out_ready;
  logic [WIDTH-1:0] d_word;
  logic             parity_err;
  logic             out_valid;

  // master: serial source and output consumer; slave: the receiver
  modport master (
    output rx_bit, bit_valid, frame_start, out_ready,
    input  d_word, parity_err, out_valid
  );
  modport slave (
    input  rx_bit, bit_valid, frame_start, out_ready,
    output d_word, parity_err, out_valid
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Bit-serial even-parity frame receiver: {d_word, parity} MSB-first, output
// over valid/ready, plus a saturating parity-error counter and a sticky overrun.
module parity_frame_rx #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  parity_frame_rx_if.slave bus,
  input  logic             clr_status,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dword_q;
  logic             perr_q;
  logic             ovalid_q;
  logic             overrun_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic start, done, frame_perr, accept, load, drop;

  always_comb begin
    start      = bus.bit_valid & bus.frame_start;
    // frame_start in the final slot restarts instead of completing
    done       = (state_q == SHIFT) & bus.bit_valid & ~bus.frame_start &
                 (cnt_q == CW'(WIDTH));
    frame_perr = ^{sr_q, bus.rx_bit};
    accept     = ovalid_q & bus.out_ready;
    load       = done & (~ovalid_q | bus.out_ready);
    drop       = done & ovalid_q & ~bus.out_ready;
    err_cnt_d  = err_cnt_q;
    if (clr_status)
      err_cnt_d = '0;
    else if (done && frame_perr && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      dword_q   <= '0;
      perr_q    <= 1'b0;
      ovalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= WIDTH'(bus.rx_bit);
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (start) begin
            sr_q  <= WIDTH'(bus.rx_bit);
            cnt_q <= CW'(1);
          end else if (done) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (bus.bit_valid) begin
            sr_q  <= WIDTH'({sr_q, bus.rx_bit});
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // a completing frame may replace a word being accepted this same cycle
      if (load) begin
        dword_q  <= sr_q;
        perr_q   <= frame_perr;
        ovalid_q <= 1'b1;
      end else if (accept) begin
        ovalid_q <= 1'b0;
      end

      if (clr_status)
        overrun_q <= 1'b0;
      else if (drop)
        overrun_q <= 1'b1;

      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.d_word     = dword_q;
  assign bus.parity_err = perr_q;
  assign bus.out_valid  = ovalid_q;
  assign busy           = (state_q == SHIFT);
  assign overrun        = overrun_q;
  assign err_cnt        = err_cnt_q;
endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx (WIDTH=8, CNT_W=4) with a queue-based
// scoreboard checked by an independent output monitor.
module tb_parity_frame_rx;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clr_status;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] err_cnt;

  int tests = 0;
  int fails = 0;
  logic [WIDTH:0] exp_q[$];

  parity_frame_rx_if #(.WIDTH(WIDTH)) bus ();

  parity_frame_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .clr_status (clr_status),
    .busy       (busy),
    .overrun    (overrun),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: each negedge with valid&ready is one transfer at the next posedge
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      logic [WIDTH:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got word %0h perr %0b, nothing expected",
                 bus.d_word, bus.parity_err);
      end else begin
        e = exp_q.pop_front();
        if ({bus.d_word, bus.parity_err} !== e) begin
          fails++;
          $display("FAIL output: got word %0h perr %0b expected word %0h perr %0b",
                   bus.d_word, bus.parity_err, e[WIDTH:1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // bits[8] goes first (d_word MSB), bits[0] is the parity bit
  task automatic send_frame(input logic [WIDTH:0] bits, input int gap,
                            input bit chk_busy, input bit rdy_last);
    for (int i = WIDTH; i >= 0; i--) begin
      bus.bit_valid   = 1'b1;
      bus.frame_start = (i == WIDTH);
      bus.rx_bit      = bits[i];
      if (i == 0 && rdy_last) bus.out_ready = 1'b1;
      tick();
      bus.bit_valid   = 1'b0;
      bus.frame_start = 1'b0;
      if (i != 0) begin
        if (chk_busy) chk("busy_during_rx", busy, 1);
        repeat (gap) begin
          tick();
          if (chk_busy) chk("busy_in_gap", busy, 1);
        end
      end
    end
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    clr_status      = 1'b0;
    bus.rx_bit      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_d_word", bus.d_word, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset_n = 1'b1;
    tick();

    // 1: clean 0xA5 frame
    exp_q.push_back({8'hA5, 1'b0});
    send_frame({8'hA5, 1'b0}, 0, 1'b0, 1'b0);
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_idle_busy", busy, 0);
    tick();

    // 2: bad parity with idle gaps between bits
    exp_q.push_back({8'hA5, 1'b1});
    send_frame({8'hA5, 1'b1}, 2, 1'b1, 1'b0);
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_busy_after", busy, 0);
    tick();

    // 3: overrun with the output stalled, then status clear
    pulse_clr();
    chk("t3_clr_err_cnt", err_cnt, 0);
    bus.out_ready = 1'b0;
    exp_q.push_back({8'h3C, 1'b0});
    send_frame({8'h3C, 1'b0}, 0, 1'b0, 1'b0);
    send_frame({8'hFF, 1'b1}, 0, 1'b0, 1'b0);
    chk("t3_held_word", bus.d_word, 8'h3C);
    chk("t3_held_perr", bus.parity_err, 0);
    chk("t3_overrun", overrun, 1);
    chk("t3_err_cnt", err_cnt, 1);
    pulse_clr();
    chk("t3_overrun_clr", overrun, 0);
    chk("t3_err_cnt_clr", err_cnt, 0);
    chk("t3_valid_kept", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    repeat (2) tick();

    // 4: restart after 4 bits, then error counter saturation
    for (int i = 0; i < 4; i++) begin
      bus.bit_valid   = 1'b1;
      bus.frame_start = (i == 0);
      bus.rx_bit      = 1'b1;
      tick();
    end
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    exp_q.push_back({8'h81, 1'b0});
    send_frame({8'h81, 1'b0}, 0, 1'b0, 1'b0);
    chk("t4_no_err", err_cnt, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({8'h01, 1'b1});
      send_frame({8'h01, 1'b0}, 0, 1'b0, 1'b0);
      if (i == 14) chk("t4_err_cnt_15", err_cnt, 15);
    end
    chk("t4_err_cnt_sat", err_cnt, 4'hF);
    chk("t4_no_overrun", overrun, 0);
    repeat (2) tick();

    // 5: asynchronous reset mid-frame with a word pending
    bus.out_ready = 1'b0;
    send_frame({8'h55, 1'b0}, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid   = 1'b1;
      bus.frame_start = (i == 0);
      bus.rx_bit      = 1'b1;
      tick();
    end
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    chk("t5_pre_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", bus.out_valid, 0);
    chk("t5_rst_d_word", bus.d_word, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_err_cnt", err_cnt, 0);
    chk("t5_rst_perr", bus.parity_err, 0);
    exp_q.delete();
    tick();
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    exp_q.push_back({8'h01, 1'b0});
    send_frame({8'h01, 1'b1}, 0, 1'b0, 1'b0);
    chk("t5_word", bus.d_word, 8'h01);
    chk("t5_perr", bus.parity_err, 0);
    repeat (2) tick();

    // 6: completion in the same cycle the pending word is accepted
    bus.out_ready = 1'b0;
    exp_q.push_back({8'h12, 1'b0});
    send_frame({8'h12, 1'b0}, 0, 1'b0, 1'b0);
    exp_q.push_back({8'h34, 1'b0});
    send_frame({8'h34, 1'b1}, 0, 1'b0, 1'b1);
    chk("t6_valid_stays", bus.out_valid, 1);
    chk("t6_new_word", bus.d_word, 8'h34);
    chk("t6_no_overrun", overrun, 0);
    repeat (3) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
